// File: rtl/sm18a.sv
// sm18a: pipelined two's-complement to sign-magnitude converter with peak tracking.
//
// It takes a two's-complement sample and returns its sign and saturated absolute value. The most
// negative code has no positive counterpart, so its magnitude saturates to all ones and OVF is
// raised. PK holds the largest magnitude produced since the last clear or reset.
//
// Ports:
//   CLK   in   clock; all state changes on the rising edge
//   RST   in   synchronous active-high reset; takes priority over VI and PCLR
//   VI    in   input valid strobe; a sample may arrive every cycle
//   D     in   [WIDTH-1:0] two's-complement sample
//   VO    out  output valid; high for one cycle per sample, two cycles after VI
//   S     out  sign of the sample (1 = negative)
//   M     out  [WIDTH-2:0] saturated magnitude
//   OVF   out  high with VO when the sample was the most negative code
//   PCLR  in   peak clear strobe
//   PK    out  [WIDTH-2:0] running peak of M
module sm18a #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VI,
    input  logic [WIDTH-1:0] D,
    output logic             VO,
    output logic             S,
    output logic [WIDTH-2:0] M,
    output logic             OVF,
    input  logic             PCLR,
    output logic [WIDTH-2:0] PK
);

    // Stage 1 registers
    logic [WIDTH-1:0] d_q, d_d;
    logic             v1_q, v1_d;

    // Stage 2 registers
    logic             vo_q, vo_d;
    logic             s_q, s_d;
    logic [WIDTH-2:0] m_q, m_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-2:0] pk_q, pk_d;

    // Conversion of the stage 1 word
    logic             sign;
    logic [WIDTH-1:0] neg;
    logic             is_min;
    logic [WIDTH-2:0] new_m;

    always_comb begin
        sign   = d_q[WIDTH-1];
        neg    = ~d_q + {{(WIDTH-1){1'b0}}, 1'b1};
        // -2^(WIDTH-1) negates to itself; its low bits would read as zero, so saturate instead.
        is_min = sign && (d_q[WIDTH-2:0] == '0);
        if (is_min) begin
            new_m = {(WIDTH-1){1'b1}};
        end else if (sign) begin
            new_m = neg[WIDTH-2:0];
        end else begin
            new_m = d_q[WIDTH-2:0];
        end
    end

    always_comb begin
        d_d   = d_q;
        v1_d  = VI;
        vo_d  = v1_q;
        s_d   = s_q;
        m_d   = m_q;
        ovf_d = ovf_q;
        pk_d  = pk_q;

        if (VI) begin
            d_d = D;
        end

        if (v1_q) begin
            s_d   = sign;
            m_d   = new_m;
            ovf_d = is_min;
            // A clear coinciding with a load restarts the peak at that sample.
            if (PCLR || (new_m > pk_q)) begin
                pk_d = new_m;
            end
        end else if (PCLR) begin
            pk_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_q   <= '0;
            v1_q  <= 1'b0;
            vo_q  <= 1'b0;
            s_q   <= 1'b0;
            m_q   <= '0;
            ovf_q <= 1'b0;
            pk_q  <= '0;
        end else begin
            d_q   <= d_d;
            v1_q  <= v1_d;
            vo_q  <= vo_d;
            s_q   <= s_d;
            m_q   <= m_d;
            ovf_q <= ovf_d;
            pk_q  <= pk_d;
        end
    end

    assign VO  = vo_q;
    assign S   = s_q;
    assign M   = m_q;
    assign OVF = ovf_q;
    assign PK  = pk_q;

endmodule
